// File: rtl/phase_softmax_array_if.sv
// Bus bundle for the spiking soft-max stage: relevance/window control in,
// spikes and published window statistics out.
interface phase_softmax_array_if #(
  parameter int N_CH   = 6,
  parameter int IN_W   = 8,
  parameter int RATE_W = 8,
  parameter int IDX_W  = 3
);
  logic [N_CH*IN_W-1:0]   rel_flat;
  logic                   cycle_start;
  logic                   inhibit_en;
  logic [N_CH-1:0]        spike;
  logic [N_CH*RATE_W-1:0] rate_flat;
  logic [IDX_W-1:0]       winner;
  logic [IDX_W-1:0]       runner_up;
  logic [RATE_W-1:0]      margin;
  logic                   rate_valid;
  logic                   overrun;

  modport master (
    output rel_flat, cycle_start, inhibit_en,
    input  spike, rate_flat, winner, runner_up, margin, rate_valid, overrun
  );

  modport slave (
    input  rel_flat, cycle_start, inhibit_en,
    output spike, rate_flat, winner, runner_up, margin, rate_valid, overrun
  );
endinterface

// File: rtl/phase_softmax_array.sv
// N-channel spiking soft-max / winner-take-all stage. Integrate-and-fire
// channels with optional lateral inhibition; spike counts per phase window are
// scanned sequentially to publish rates, winner, runner-up and margin.
module phase_softmax_array #(
  parameter int N_CH         = 6,
  parameter int IN_W         = 8,
  parameter int ACC_W        = 10,
  parameter int THRESHOLD    = 256,
  parameter int INHIBIT_GAIN = 4,
  parameter int RATE_W       = 8,
  parameter int IDX_W        = 3
) (
  input logic                  clk,
  input logic                  rst_n,
  phase_softmax_array_if.slave bus
);

  localparam int PC_W  = $clog2(N_CH + 1);
  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [0:0] {ST_IDLE, ST_SCAN} state_t;

  state_t state_q, state_d;

  logic [ACC_W-1:0]  acc_q  [N_CH];
  logic [ACC_W-1:0]  acc_d  [N_CH];
  logic [SUM_W-1:0]  sum_c  [N_CH];
  logic [SUM_W-1:0]  diff_c [N_CH];
  logic [N_CH-1:0]   spike_q;
  logic [N_CH-1:0]   fire;
  logic [PC_W-1:0]   pop;
  logic [SUM_W-1:0]  inh;

  logic [RATE_W-1:0] cnt_q  [N_CH];
  logic [RATE_W-1:0] snap_q [N_CH];
  logic [RATE_W-1:0] rate_q [N_CH];

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  best_idx_q, sec_idx_q, nb_idx, ns_idx;
  logic [RATE_W-1:0] best_r_q, sec_r_q, nb_r, ns_r, cur_r;
  logic              best_v_q, sec_v_q, nb_v, ns_v;
  logic              last_idx;
  logic              publish;

  logic [IDX_W-1:0]  winner_q, runner_up_q;
  logic [RATE_W-1:0] margin_q;
  logic              rate_valid_q, overrun_q;

  // Inhibition strength from last clock's registered spikes
  always_comb begin
    pop = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      pop = pop + PC_W'(spike_q[i]);
    end
    inh = bus.inhibit_en ? SUM_W'(INHIBIT_GAIN) * SUM_W'(pop) : '0;
  end

  // Integrate-and-fire per channel; firing channels skip inhibition
  always_comb begin
    fire = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      sum_c[i] = {1'b0, acc_q[i]} + SUM_W'(bus.rel_flat[i*IN_W +: IN_W]);
      fire[i]  = (sum_c[i] >= SUM_W'(THRESHOLD));
      if (fire[i]) begin
        diff_c[i] = sum_c[i] - SUM_W'(THRESHOLD);
      end else if (sum_c[i] > inh) begin
        diff_c[i] = sum_c[i] - inh;
      end else begin
        diff_c[i] = '0;
      end
      acc_d[i] = diff_c[i][ACC_W-1:0];
    end
  end

  // Accumulator and spike registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_q <= '0;
      for (int unsigned i = 0; i < N_CH; i++) acc_q[i] <= '0;
    end else begin
      spike_q <= fire;
      for (int unsigned i = 0; i < N_CH; i++) acc_q[i] <= acc_d[i];
    end
  end

  // Saturating window counters; a spike on the boundary clock opens the new window
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        cnt_q[i]  <= '0;
        snap_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (bus.cycle_start) begin
          snap_q[i] <= cnt_q[i];
          cnt_q[i]  <= spike_q[i] ? RATE_W'(1) : '0;
        end else if (spike_q[i] && (cnt_q[i] != '1)) begin
          cnt_q[i] <= cnt_q[i] + RATE_W'(1);
        end
      end
    end
  end

  assign last_idx = (idx_q == IDX_W'(N_CH - 1));

  // Scan FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state; a boundary during SCAN restarts the scan instead of publishing
  always_comb begin
    state_d = state_q;
    publish = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cycle_start) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (bus.cycle_start) begin
          state_d = ST_SCAN;
        end else if (last_idx) begin
          state_d = ST_IDLE;
          publish = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Best / second-best update for the channel under the scan pointer
  always_comb begin
    cur_r  = snap_q[idx_q];
    nb_idx = best_idx_q;
    nb_r   = best_r_q;
    nb_v   = best_v_q;
    ns_idx = sec_idx_q;
    ns_r   = sec_r_q;
    ns_v   = sec_v_q;
    if (!best_v_q || (cur_r > best_r_q)) begin
      ns_idx = best_idx_q;
      ns_r   = best_r_q;
      ns_v   = best_v_q;
      nb_idx = idx_q;
      nb_r   = cur_r;
      nb_v   = 1'b1;
    end else if (!sec_v_q || (cur_r > sec_r_q)) begin
      ns_idx = idx_q;
      ns_r   = cur_r;
      ns_v   = 1'b1;
    end
  end

  // Scan datapath and published outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      sec_idx_q    <= '0;
      best_r_q     <= '0;
      sec_r_q      <= '0;
      best_v_q     <= 1'b0;
      sec_v_q      <= 1'b0;
      winner_q     <= '0;
      runner_up_q  <= IDX_W'(1);
      margin_q     <= '0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
      for (int unsigned i = 0; i < N_CH; i++) rate_q[i] <= '0;
    end else begin
      rate_valid_q <= publish;
      if (bus.cycle_start) begin
        idx_q    <= '0;
        best_v_q <= 1'b0;
        sec_v_q  <= 1'b0;
        if (state_q == ST_SCAN) overrun_q <= 1'b1;
      end else if (state_q == ST_SCAN) begin
        idx_q      <= idx_q + IDX_W'(1);
        best_idx_q <= nb_idx;
        best_r_q   <= nb_r;
        best_v_q   <= nb_v;
        sec_idx_q  <= ns_idx;
        sec_r_q    <= ns_r;
        sec_v_q    <= ns_v;
      end
      if (publish) begin
        winner_q    <= nb_idx;
        runner_up_q <= ns_idx;
        margin_q    <= nb_r - ns_r;
        rate_q      <= snap_q;
      end
    end
  end

  // Flatten published rates onto the bus
  always_comb begin
    bus.rate_flat = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      bus.rate_flat[i*RATE_W +: RATE_W] = rate_q[i];
    end
  end

  assign bus.spike      = spike_q;
  assign bus.winner     = winner_q;
  assign bus.runner_up  = runner_up_q;
  assign bus.margin     = margin_q;
  assign bus.rate_valid = rate_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_phase_softmax_array.sv
// Directed bench for phase_softmax_array: reset, rate ranges under several
// relevance patterns, publish latency/overrun, reset mid-scan, saturation.
module tb_phase_softmax_array;

  localparam int N_CH   = 6;
  localparam int IN_W   = 8;
  localparam int ACC_W  = 10;
  localparam int RATE_W = 8;
  localparam int IDX_W  = 3;
  localparam int SAT_W  = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  phase_softmax_array_if #(.N_CH(N_CH), .IN_W(IN_W), .RATE_W(RATE_W), .IDX_W(IDX_W)) bus ();
  phase_softmax_array_if #(.N_CH(N_CH), .IN_W(IN_W), .RATE_W(SAT_W),  .IDX_W(IDX_W)) sbus ();

  phase_softmax_array #(
    .N_CH(N_CH), .IN_W(IN_W), .ACC_W(ACC_W), .THRESHOLD(256),
    .INHIBIT_GAIN(4), .RATE_W(RATE_W), .IDX_W(IDX_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  phase_softmax_array #(
    .N_CH(N_CH), .IN_W(IN_W), .ACC_W(ACC_W), .THRESHOLD(256),
    .INHIBIT_GAIN(4), .RATE_W(SAT_W), .IDX_W(IDX_W)
  ) dut_sat (
    .clk(clk), .rst_n(rst_n), .bus(sbus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int r  [N_CH];
  int rs [N_CH];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_rel(input int v0, input int vmid, input int v5);
    for (int i = 0; i < N_CH; i++) begin
      bus.rel_flat[i*IN_W +: IN_W] = IN_W'((i == 0) ? v0 : ((i == 5) ? v5 : vmid));
    end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    bus.cycle_start = 1'b0;
    sbus.cycle_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic pulse_main();
    bus.cycle_start = 1'b1;
    @(posedge clk);
    #1 bus.cycle_start = 1'b0;
  endtask

  task automatic pulse_sat();
    sbus.cycle_start = 1'b1;
    @(posedge clk);
    #1 sbus.cycle_start = 1'b0;
  endtask

  // Window of exactly w clocks between two boundaries, then wait for the publish
  task automatic measure_main(input int w, output bit ok);
    ok = 1'b0;
    pulse_main();
    repeat (w - 1) begin @(posedge clk); #1; end
    pulse_main();
    for (int k = 0; k < N_CH + 4; k++) begin
      @(posedge clk); #1;
      if (bus.rate_valid) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < N_CH; i++) r[i] = int'(bus.rate_flat[i*RATE_W +: RATE_W]);
  endtask

  task automatic measure_sat(input int w, output bit ok);
    ok = 1'b0;
    pulse_sat();
    repeat (w - 1) begin @(posedge clk); #1; end
    pulse_sat();
    for (int k = 0; k < N_CH + 4; k++) begin
      @(posedge clk); #1;
      if (sbus.rate_valid) begin ok = 1'b1; break; end
    end
    for (int i = 0; i < N_CH; i++) rs[i] = int'(sbus.rate_flat[i*SAT_W +: SAT_W]);
  endtask

  task automatic test_reset();
    bus.rel_flat = '0; bus.inhibit_en = 1'b0;
    sbus.rel_flat = '0; sbus.inhibit_en = 1'b0;
    apply_reset();
    tests_run++; if (bus.spike !== '0) begin tests_failed++; $display("FAIL reset_spike: got %0h expected 0", bus.spike); end
    tests_run++; if (bus.rate_flat !== '0) begin tests_failed++; $display("FAIL reset_rate: got %0h expected 0", bus.rate_flat); end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL reset_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL reset_runner_up: got %0d expected 1", bus.runner_up); end
    tests_run++; if (bus.margin !== '0) begin tests_failed++; $display("FAIL reset_margin: got %0d expected 0", bus.margin); end
    tests_run++; if (bus.rate_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_rate_valid: got %0b expected 0", bus.rate_valid); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL reset_overrun: got %0b expected 0", bus.overrun); end
  endtask

  task automatic test_uniform();
    bit ok;
    apply_reset();
    bus.inhibit_en = 1'b0;
    set_rel(200, 200, 200);
    measure_main(256, ok);
    measure_main(256, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL uniform_valid: got 0 expected 1"); end
    for (int i = 0; i < N_CH; i++) begin
      tests_run++;
      if (r[i] < 199 || r[i] > 201) begin tests_failed++; $display("FAIL uniform_free_rate%0d: got %0d expected 199..201", i, r[i]); end
    end
    bus.inhibit_en = 1'b1;
    measure_main(256, ok);
    measure_main(256, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL uniform_inh_valid: got 0 expected 1"); end
    tests_run++; if (r[0] < 180 || r[0] > 201) begin tests_failed++; $display("FAIL uniform_inh_rate0: got %0d expected 180..201", r[0]); end
    for (int i = 1; i < N_CH; i++) begin
      tests_run++;
      if (r[i] != r[0]) begin tests_failed++; $display("FAIL uniform_equal%0d: got %0d expected %0d", i, r[i], r[0]); end
    end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL uniform_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL uniform_runner_up: got %0d expected 1", bus.runner_up); end
    tests_run++; if (bus.margin !== '0) begin tests_failed++; $display("FAIL uniform_margin: got %0d expected 0", bus.margin); end
  endtask

  task automatic test_single();
    bit ok;
    bus.inhibit_en = 1'b1;
    set_rel(255, 0, 0);
    measure_main(256, ok);
    measure_main(256, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL single_valid: got 0 expected 1"); end
    tests_run++; if (r[0] < 254 || r[0] > 255) begin tests_failed++; $display("FAIL single_rate0: got %0d expected 254..255", r[0]); end
    for (int i = 1; i < N_CH; i++) begin
      tests_run++;
      if (r[i] != 0) begin tests_failed++; $display("FAIL single_rate%0d: got %0d expected 0", i, r[i]); end
    end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL single_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL single_runner_up: got %0d expected 1", bus.runner_up); end
    tests_run++; if (int'(bus.margin) != r[0]) begin tests_failed++; $display("FAIL single_margin: got %0d expected %0d", bus.margin, r[0]); end
  endtask

  task automatic test_competition();
    bit ok;
    int others_free, others_inh;
    bus.inhibit_en = 1'b0;
    set_rel(254, 100, 252);
    measure_main(256, ok);
    measure_main(256, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL comp_free_valid: got 0 expected 1"); end
    tests_run++; if (r[0] < 253 || r[0] > 255) begin tests_failed++; $display("FAIL comp_free_rate0: got %0d expected 253..255", r[0]); end
    tests_run++; if (r[5] < 251 || r[5] > 253) begin tests_failed++; $display("FAIL comp_free_rate5: got %0d expected 251..253", r[5]); end
    tests_run++; if (r[2] < 99 || r[2] > 101) begin tests_failed++; $display("FAIL comp_free_rate2: got %0d expected 99..101", r[2]); end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL comp_free_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd5) begin tests_failed++; $display("FAIL comp_free_runner_up: got %0d expected 5", bus.runner_up); end
    tests_run++; if (int'(bus.margin) != r[0] - r[5]) begin tests_failed++; $display("FAIL comp_free_margin: got %0d expected %0d", bus.margin, r[0] - r[5]); end
    others_free = r[1] + r[2] + r[3] + r[4];
    bus.inhibit_en = 1'b1;
    measure_main(256, ok);
    measure_main(256, ok);
    others_inh = r[1] + r[2] + r[3] + r[4];
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL comp_inh_valid: got 0 expected 1"); end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL comp_inh_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd5) begin tests_failed++; $display("FAIL comp_inh_runner_up: got %0d expected 5", bus.runner_up); end
    tests_run++; if (int'(bus.margin) != r[0] - r[5]) begin tests_failed++; $display("FAIL comp_inh_margin: got %0d expected %0d", bus.margin, r[0] - r[5]); end
    tests_run++; if (r[5] < 240 || r[5] > 253) begin tests_failed++; $display("FAIL comp_inh_rate5: got %0d expected 240..253", r[5]); end
    tests_run++; if (others_inh >= others_free) begin tests_failed++; $display("FAIL comp_inh_suppress: got %0d expected below %0d", others_inh, others_free); end
  endtask

  task automatic test_timing();
    bus.inhibit_en = 1'b0;
    set_rel(200, 200, 200);
    bus.cycle_start = 1'b1;
    for (int k = 1; k <= N_CH + 3; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.cycle_start = 1'b0;
      tests_run++;
      if (bus.rate_valid !== (k == N_CH + 1)) begin
        tests_failed++; $display("FAIL latency_k%0d: got %0b expected %0b", k, bus.rate_valid, (k == N_CH + 1));
      end
    end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL no_overrun: got %0b expected 0", bus.overrun); end
    bus.cycle_start = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      @(posedge clk); #1;
      if (k == 1 || k == 4) bus.cycle_start = 1'b0;
      tests_run++;
      if (bus.rate_valid !== (k == 10)) begin
        tests_failed++; $display("FAIL overrun_valid_k%0d: got %0b expected %0b", k, bus.rate_valid, (k == 10));
      end
      if (k == 3) begin
        tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL overrun_early: got %0b expected 0", bus.overrun); end
        bus.cycle_start = 1'b1;
      end
      if (k == 4 || k == 13) begin
        tests_run++; if (bus.overrun !== 1'b1) begin tests_failed++; $display("FAIL overrun_set_k%0d: got %0b expected 1", k, bus.overrun); end
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    pulse_main();
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    tests_run++; if (bus.spike !== '0) begin tests_failed++; $display("FAIL rst_mid_spike: got %0h expected 0", bus.spike); end
    tests_run++; if (bus.rate_flat !== '0) begin tests_failed++; $display("FAIL rst_mid_rate: got %0h expected 0", bus.rate_flat); end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL rst_mid_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL rst_mid_runner_up: got %0d expected 1", bus.runner_up); end
    tests_run++; if (bus.margin !== '0) begin tests_failed++; $display("FAIL rst_mid_margin: got %0d expected 0", bus.margin); end
    tests_run++; if (bus.overrun !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_overrun: got %0b expected 0", bus.overrun); end
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 1; k <= N_CH + 3; k++) begin
      @(posedge clk); #1;
      tests_run++;
      if (bus.rate_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_mid_stale_valid_k%0d: got 1 expected 0", k); end
    end
    bus.cycle_start = 1'b1;
    for (int k = 1; k <= N_CH + 2; k++) begin
      @(posedge clk); #1;
      if (k == 1) bus.cycle_start = 1'b0;
      tests_run++;
      if (bus.rate_valid !== (k == N_CH + 1)) begin
        tests_failed++; $display("FAIL resume_valid_k%0d: got %0b expected %0b", k, bus.rate_valid, (k == N_CH + 1));
      end
    end
    tests_run++; if (bus.winner !== 3'd0) begin tests_failed++; $display("FAIL resume_winner: got %0d expected 0", bus.winner); end
    tests_run++; if (bus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL resume_runner_up: got %0d expected 1", bus.runner_up); end
    tests_run++; if (bus.margin !== '0) begin tests_failed++; $display("FAIL resume_margin: got %0d expected 0", bus.margin); end
  endtask

  task automatic test_saturation();
    bit ok;
    sbus.inhibit_en = 1'b0;
    for (int i = 0; i < N_CH; i++) sbus.rel_flat[i*IN_W +: IN_W] = (i == 0) ? 8'd255 : 8'd0;
    apply_reset();
    repeat (5) begin @(posedge clk); #1; end
    // channel 0 spikes every clock here, so the boundary spike makes the count exactly 10
    measure_sat(10, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL sat_boundary_valid: got 0 expected 1"); end
    tests_run++; if (rs[0] != 10) begin tests_failed++; $display("FAIL sat_boundary_rate0: got %0d expected 10", rs[0]); end
    tests_run++; if (rs[1] != 0) begin tests_failed++; $display("FAIL sat_boundary_rate1: got %0d expected 0", rs[1]); end
    measure_sat(40, ok);
    tests_run++; if (!ok) begin tests_failed++; $display("FAIL sat_valid: got 0 expected 1"); end
    tests_run++; if (rs[0] != 15) begin tests_failed++; $display("FAIL sat_rate0: got %0d expected 15", rs[0]); end
    tests_run++; if (sbus.winner !== 3'd0) begin tests_failed++; $display("FAIL sat_winner: got %0d expected 0", sbus.winner); end
    tests_run++; if (sbus.runner_up !== 3'd1) begin tests_failed++; $display("FAIL sat_runner_up: got %0d expected 1", sbus.runner_up); end
    tests_run++; if (sbus.margin !== 4'd15) begin tests_failed++; $display("FAIL sat_margin: got %0d expected 15", sbus.margin); end
  endtask

  initial begin
    bus.rel_flat = '0;
    bus.cycle_start = 1'b0;
    bus.inhibit_en = 1'b0;
    sbus.rel_flat = '0;
    sbus.cycle_start = 1'b0;
    sbus.inhibit_en = 1'b0;
    test_reset();
    test_uniform();
    test_single();
    test_competition();
    test_timing();
    test_reset_mid_scan();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
